// File: rtl/cordic_tx_pkg.sv
// cordic_tx_pkg: shared widths, FSM states and output word layout for cordic_operand_tx
package cordic_tx_pkg;
   localparam int INPUT_DATA_WIDTH = 49;
   localparam int DATA_WIDTH = 56;
   localparam int TAG_WIDTH = DATA_WIDTH - INPUT_DATA_WIDTH;
   typedef enum logic [1:0] {IDLE, GAP, CREDIT_WAIT} state_t;
   typedef struct packed {
      logic [TAG_WIDTH-1:0] tag;
      logic [INPUT_DATA_WIDTH-1:0] payload;
   } tx_word_t;
endpackage

// File: rtl/cordic_operand_tx_if.sv
// cordic_operand_tx_if: upstream payload handshake, wrapper issue bus and credit return
interface cordic_operand_tx_if;
   import cordic_tx_pkg::*;
   logic i_in_vld;
   logic o_in_rdy;
   logic [INPUT_DATA_WIDTH-1:0] i_in_data;
   logic o_vld;
   tx_word_t o_data;
   logic i_ret_vld;
   modport master (output i_in_vld, i_in_data, i_ret_vld, input o_in_rdy, o_vld, o_data);
   modport slave (input i_in_vld, i_in_data, i_ret_vld, output o_in_rdy, o_vld, o_data);
endinterface

// File: rtl/cordic_tx_fifo.sv
// cordic_tx_fifo: synchronous FIFO with a combinational head read
module cordic_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 49,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data,
   output logic [CW-1:0]    o_count,
   output logic             o_full,
   output logic             o_empty
);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, rd_q;
   logic [CW-1:0] cnt_q;
   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_q] <= i_data;
      if (i_rst) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         if (i_push) wr_q <= wr_q + 1'b1;
         if (i_pop) rd_q <= rd_q + 1'b1;
         cnt_q <= cnt_q + CW'(i_push) - CW'(i_pop);
      end
   end
   assign o_data = mem_q[rd_q];
   assign o_count = cnt_q;
   assign o_full = cnt_q == CW'(DEPTH);
   assign o_empty = cnt_q == '0;
endmodule

// File: rtl/cordic_operand_tx.sv
// cordic_operand_tx: buffers operands, tags them and issues them to the CORDIC wrapper,
// throttled by a minimum inter-issue gap and a credit count of unreturned operations
module cordic_operand_tx
   import cordic_tx_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int MAX_OUTSTANDING = 12,
   localparam int OW = $clog2(MAX_OUTSTANDING + 1),
   localparam int CW = $clog2(FIFO_DEPTH + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_en,
   input  logic [3:0]        i_gap,
   cordic_operand_tx_if.slave bus,
   output logic [OW-1:0]     o_outstanding,
   output logic              o_busy,
   output logic              o_ovf_err
);
   localparam logic [OW-1:0] MAX_Q = OW'(MAX_OUTSTANDING);
   logic [INPUT_DATA_WIDTH-1:0] head;
   logic [CW-1:0] count;
   logic full, empty, push, issue;
   state_t state_q;
   logic [3:0] gap_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic [OW-1:0] out_q, out_d;
   logic ovf_q, ovf_d, vld_q;
   tx_word_t data_q;
   cordic_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INPUT_DATA_WIDTH)) u_fifo (
      .i_clk(i_clk),
      .i_rst(i_rst),
      .i_push(push),
      .i_pop(issue),
      .i_data(bus.i_in_data),
      .o_data(head),
      .o_count(count),
      .o_full(full),
      .o_empty(empty)
   );
   assign bus.o_in_rdy = !full && !i_rst;
   assign push = bus.i_in_vld && bus.o_in_rdy;
   assign issue = i_en && !empty && out_q < MAX_Q && gap_q == 4'd0 && state_q == IDLE;
   // a return with nothing outstanding is absorbed and flagged rather than wrapping
   assign out_d = issue == bus.i_ret_vld ? out_q : issue ? out_q + 1'b1 : out_q == '0 ? out_q : out_q - 1'b1;
   assign ovf_d = ovf_q || (bus.i_ret_vld && !issue && out_q == '0);
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         gap_q <= '0;
         tag_q <= '0;
         out_q <= '0;
         ovf_q <= 1'b0;
         vld_q <= 1'b0;
         data_q <= '0;
      end else begin
         out_q <= out_d;
         ovf_q <= ovf_d;
         vld_q <= issue;
         if (issue) begin
            data_q <= {tag_q, head};
            tag_q <= tag_q + 1'b1;
            gap_q <= i_gap;
         end
         case (state_q)
            IDLE: state_q <= issue && i_gap != 4'd0 ? GAP : !issue && !empty && out_q == MAX_Q ? CREDIT_WAIT : IDLE;
            GAP: begin
               gap_q <= gap_q - 1'b1;
               if (gap_q == 4'd1) state_q <= IDLE;
            end
            CREDIT_WAIT: if (out_q < MAX_Q) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.o_vld = vld_q;
   assign bus.o_data = data_q;
   assign o_outstanding = out_q;
   assign o_ovf_err = ovf_q;
   assign o_busy = count != '0 || out_q != '0;
endmodule

// File: tb/tb_cordic_operand_tx.sv
// tb_cordic_operand_tx: scoreboard bench; expected words and credit state come from a
// transaction-level model (n-th accepted payload carries tag n mod 128, credits = issues - returns)
module tb_cordic_operand_tx;
   import cordic_tx_pkg::*;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en = 1'b0;
   logic [3:0] gap = '0;
   logic [3:0] outstanding;
   logic busy, ovf;
   int n_checks = 0;
   int n_fail = 0;
   int n_vld = 0;
   tx_word_t exp_q[$];
   logic [TAG_WIDTH-1:0] tag_m = '0;
   bit rst_e = 1'b1;
   bit ret_e = 1'b0;
   int out_m = 0;
   bit ovf_m = 1'b0;

   cordic_operand_tx_if bus();

   cordic_operand_tx #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(12)) dut (
      .i_clk(clk),
      .i_rst(rst),
      .i_en(en),
      .i_gap(gap),
      .bus(bus),
      .o_outstanding(outstanding),
      .o_busy(busy),
      .o_ovf_err(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [INPUT_DATA_WIDTH-1:0] rand_payload();
      logic [63:0] r;
      r = {$urandom, $urandom};
      return r[INPUT_DATA_WIDTH-1:0];
   endfunction

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // record what the DUT accepted at this edge and which credit was returned
   always @(posedge clk) begin
      rst_e = rst;
      ret_e = bus.i_ret_vld;
      if (rst) begin
         exp_q.delete();
         tag_m = '0;
      end else if (bus.i_in_vld && bus.o_in_rdy) begin
         exp_q.push_back(tx_word_t'({tag_m, bus.i_in_data}));
         tag_m = tag_m + 1'b1;
      end
   end

   always @(negedge clk) begin
      tx_word_t w;
      if (rst_e) begin
         out_m = 0;
         ovf_m = 1'b0;
         check("rst_vld", 64'(bus.o_vld), 64'(0));
         check("rst_data", 64'(bus.o_data), 64'(0));
      end else begin
         if (bus.o_vld) begin
            n_vld++;
            check("sb_nonempty_on_vld", 64'(exp_q.size() != 0), 64'(1));
            if (exp_q.size() != 0) begin
               w = exp_q.pop_front();
               check("o_data", 64'(bus.o_data), 64'(w));
            end
         end
         if (bus.o_vld && !ret_e) out_m++;
         else if (!bus.o_vld && ret_e) begin
            if (out_m == 0) ovf_m = 1'b1;
            else out_m--;
         end
      end
      check("outstanding", 64'(outstanding), 64'(out_m));
      check("ovf_err", 64'(ovf), 64'(ovf_m));
      check("busy", 64'(busy), 64'(exp_q.size() != 0 || out_m != 0));
      check("in_rdy", 64'(bus.o_in_rdy), 64'(!rst && exp_q.size() < 4));
   end

   task automatic do_reset();
      rst = 1'b1;
      en = 1'b0;
      gap = '0;
      bus.i_in_vld = 1'b0;
      bus.i_ret_vld = 1'b0;
      tick();
      tick();
      rst = 1'b0;
      #1;
      check("rdy_after_rst", 64'(bus.o_in_rdy), 64'(1));
   endtask

   task automatic push_words(input int n);
      int sent = 0;
      int guard = 0;
      bit acc;
      while (sent < n && guard < 200) begin
         bus.i_in_vld = 1'b1;
         bus.i_in_data = rand_payload();
         acc = 1'b0;
         while (!acc && guard < 200) begin
            acc = bus.o_in_rdy;
            tick();
            guard++;
         end
         if (acc) sent++;
      end
      bus.i_in_vld = 1'b0;
      check("push_words_done", 64'(sent), 64'(n));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [INPUT_DATA_WIDTH-1:0] d;
      int t[$];
      int start, guard, remaining;
      bus.i_in_vld = 1'b0;
      bus.i_in_data = '0;
      bus.i_ret_vld = 1'b0;
      do_reset();
      check("reset_data", 64'(bus.o_data), 64'(0));
      check("reset_busy", 64'(busy), 64'(0));
      // single word: two-cycle latency, tag 0
      d = 49'h1_2345_6789_ABCD;
      en = 1'b1;
      bus.i_in_vld = 1'b1;
      bus.i_in_data = d;
      tick();
      bus.i_in_vld = 1'b0;
      check("t1_not_yet", 64'(bus.o_vld), 64'(0));
      tick();
      check("t1_vld", 64'(bus.o_vld), 64'(1));
      check("t1_data", 64'(bus.o_data), 64'({7'd0, d}));
      check("t1_outstanding", 64'(outstanding), 64'(1));
      tick();
      check("t1_one_cycle", 64'(bus.o_vld), 64'(0));
      // fill with issue disabled, then release back-to-back
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus.i_in_vld = 1'b1;
         bus.i_in_data = rand_payload();
         tick();
      end
      check("t2_full_rdy", 64'(bus.o_in_rdy), 64'(0));
      bus.i_in_data = rand_payload();
      tick();
      bus.i_in_vld = 1'b0;
      check("t2_no_issue_when_disabled", 64'(bus.o_vld), 64'(0));
      en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick();
         check("t2_b2b_vld", 64'(bus.o_vld), 64'(1));
         check("t2_tag", 64'(bus.o_data.tag), 64'(i));
      end
      tick();
      check("t2_fifo_drained", 64'(bus.o_vld), 64'(0));
      // credit limit
      do_reset();
      en = 1'b1;
      push_words(13);
      repeat (6) tick();
      check("t3_outstanding_max", 64'(outstanding), 64'(12));
      check("t3_state", 64'(dut.state_q), 64'(CREDIT_WAIT));
      check("t3_stalled", 64'(bus.o_vld), 64'(0));
      bus.i_ret_vld = 1'b1;
      tick();
      bus.i_ret_vld = 1'b0;
      check("t3_after_ret", 64'(outstanding), 64'(11));
      tick();
      check("t3_wait_idle", 64'(bus.o_vld), 64'(0));
      tick();
      check("t3_13th_issue", 64'(bus.o_vld), 64'(1));
      check("t3_13th_tag", 64'(bus.o_data.tag), 64'(12));
      // inter-issue gap
      do_reset();
      gap = 4'd3;
      push_words(3);
      en = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (bus.o_vld) t.push_back(c);
      end
      check("t4_count", 64'(t.size()), 64'(3));
      if (t.size() == 3) begin
         check("t4_space0", 64'(t[1] - t[0]), 64'(4));
         check("t4_space1", 64'(t[2] - t[1]), 64'(4));
      end
      gap = '0;
      // credit underflow and simultaneous issue/return
      do_reset();
      en = 1'b1;
      bus.i_ret_vld = 1'b1;
      tick();
      bus.i_ret_vld = 1'b0;
      check("t5_ovf_set", 64'(ovf), 64'(1));
      check("t5_out_zero", 64'(outstanding), 64'(0));
      repeat (3) tick();
      check("t5_ovf_sticky", 64'(ovf), 64'(1));
      bus.i_in_vld = 1'b1;
      bus.i_in_data = rand_payload();
      tick();
      bus.i_in_vld = 1'b0;
      tick();
      check("t5_out_one", 64'(outstanding), 64'(1));
      bus.i_in_vld = 1'b1;
      bus.i_in_data = rand_payload();
      tick();
      bus.i_in_vld = 1'b0;
      bus.i_ret_vld = 1'b1;
      tick();
      bus.i_ret_vld = 1'b0;
      check("t5_issue_with_ret", 64'(bus.o_vld), 64'(1));
      check("t5_out_unchanged", 64'(outstanding), 64'(1));
      // tag wrap over 130 issues with credits returned as they come back
      do_reset();
      en = 1'b1;
      start = n_vld;
      remaining = 130;
      guard = 0;
      bus.i_in_data = rand_payload();
      while ((remaining > 0 || busy) && guard < 2000) begin
         bit acc;
         bus.i_in_vld = remaining > 0;
         bus.i_ret_vld = outstanding != '0;
         acc = bus.i_in_vld && bus.o_in_rdy;
         tick();
         guard++;
         if (acc) begin
            remaining--;
            bus.i_in_data = rand_payload();
         end
      end
      bus.i_in_vld = 1'b0;
      bus.i_ret_vld = 1'b0;
      check("t6_issues", 64'(n_vld - start), 64'(130));
      check("t6_last_tag", 64'(bus.o_data.tag), 64'(1));
      // reset with queued words
      en = 1'b0;
      push_words(3);
      check("t7_busy_before", 64'(busy), 64'(1));
      rst = 1'b1;
      tick();
      check("t7_rst_vld", 64'(bus.o_vld), 64'(0));
      check("t7_rst_busy", 64'(busy), 64'(0));
      check("t7_rst_rdy", 64'(bus.o_in_rdy), 64'(0));
      rst = 1'b0;
      #1;
      check("t7_rdy_release", 64'(bus.o_in_rdy), 64'(1));
      en = 1'b1;
      bus.i_in_vld = 1'b1;
      bus.i_in_data = rand_payload();
      tick();
      bus.i_in_vld = 1'b0;
      tick();
      check("t7_vld", 64'(bus.o_vld), 64'(1));
      check("t7_tag_restart", 64'(bus.o_data.tag), 64'(0));
      // randomized traffic checked by the scoreboard and credit model
      do_reset();
      for (int c = 0; c < 400; c++) begin
         en = ($urandom % 8) != 0;
         gap = 4'($urandom % 3);
         bus.i_in_vld = ($urandom % 2) != 0;
         bus.i_in_data = rand_payload();
         bus.i_ret_vld = ($urandom % 3) == 0;
         tick();
      end
      en = 1'b1;
      bus.i_in_vld = 1'b0;
      guard = 0;
      while (busy && guard < 500) begin
         bus.i_ret_vld = outstanding != '0;
         tick();
         guard++;
      end
      bus.i_ret_vld = 1'b0;
      tick();
      check("drain_idle", 64'(busy), 64'(0));
      check("sb_empty", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/cordic_operand_tx.md
Name: cordic_operand_tx

Overview:
Transmit-side feeder for the CORDIC wrapper's input stream. It accepts operand payloads from an upstream producer over a valid/ready handshake and buffers them in a small FIFO. Each payload is tagged and driven onto the wrapper's i_vld/i_data bus. Outstanding operations are limited by a credit counter, which is replenished by the wrapper's o_vld result strobe.

Parameters:
INPUT_DATA_WIDTH, 49, payload width per operation
DATA_WIDTH, 56, wrapper data bus width
FIFO_DEPTH, 4, operand buffer entries (power of 2, >=2)
MAX_OUTSTANDING, 12, max issued-but-unreturned operations (matches NUM_MICRO_ROTATION)
TAG_WIDTH, DATA_WIDTH-INPUT_DATA_WIDTH (=7), localparam, sequence tag width

Ports:
i_clk  in  1  clock, all logic on rising edge
i_rst  in  1  synchronous reset, active-high
i_en  in  1  issue enable; low blocks issue only
i_gap  in  4  minimum idle cycles between consecutive issues
i_in_vld  in  1  upstream payload valid
o_in_rdy  out  1  FIFO can accept
i_in_data  in  INPUT_DATA_WIDTH  upstream payload
o_vld  out  1  to wrapper i_vld
o_data  out  DATA_WIDTH  to wrapper i_data, {tag, payload}
i_ret_vld  in  1  wrapper o_vld, returns one credit
o_outstanding  out  $clog2(MAX_OUTSTANDING+1)  current issued-unreturned count
o_busy  out  1  FIFO non-empty or outstanding != 0
o_ovf_err  out  1  sticky: credit returned while outstanding == 0

Behaviour:
- Reset values, applied at the i_rst edge, including mid-operation: FIFO emptied with pointers at 0, tag 0, outstanding 0, gap counter 0, state IDLE. Outputs: o_vld 0, o_data 0, o_ovf_err 0, o_busy 0. o_in_rdy is 0 while i_rst is high and 1 on the first cycle after. In-flight payloads are discarded.
- Push: occurs when i_in_vld && o_in_rdy at the edge. o_in_rdy = (count < FIFO_DEPTH), decoded from the registered count only. At full, a same-cycle pop does not enable a push.
- Issue condition: i_en && FIFO non-empty && outstanding < MAX_OUTSTANDING && gap counter == 0 && state IDLE. The outstanding value used is the registered value; a same-cycle i_ret_vld does not unblock issue.
- Issue action, taken at the edge:
  - pop the FIFO head;
  - o_vld <= 1 and o_data <= {tag, head} for exactly one cycle;
  - tag <= tag+1, wrapping mod 2^TAG_WIDTH (127 -> 0);
  - gap counter <= i_gap, sampled at the issue edge.
- o_vld and o_data are registered. When no issue occurs, o_vld is 0 and o_data holds its last value.
- Latency: with an empty FIFO and all other conditions true, a payload accepted at edge k appears with o_vld high in the cycle after edge k+1 (2-cycle latency). With i_gap=0, back-to-back issue yields one word per cycle.
- FSM:
  - IDLE: issue whenever the condition holds. Go to GAP if i_gap != 0; stay in IDLE if i_gap == 0.
  - GAP: decrement the gap counter; go to IDLE when it reaches 1 -> 0.
  - CREDIT_WAIT: entered from IDLE when the FIFO is non-empty and outstanding == MAX_OUTSTANDING. Return to IDLE on the first cycle outstanding < MAX.
  - i_en low: no issue in any state. The gap counter still counts down.
- Outstanding counter:
  - issue only: +1;
  - i_ret_vld only: -1;
  - both in the same cycle: unchanged;
  - i_ret_vld with outstanding == 0 and no issue: stays 0 and sets o_ovf_err, which clears only on reset.
- o_busy is combinational from the registered FIFO count and outstanding.

Decomposition:
- Package cordic_tx_pkg holds:
  - typedef enum state_t {IDLE, GAP, CREDIT_WAIT};
  - TAG_WIDTH derivation;
  - packed struct tx_word_t {tag, payload} for o_data.
- Sub-module cordic_tx_fifo: synchronous FIFO, DEPTH x INPUT_DATA_WIDTH.
  - Ports: push, pop, data in/out, registered count, full, empty.
  - Read data is the combinational head.
- The top level contains the FSM, tag counter, gap counter and credit counter.

Test Plan:
- Reset then a single push of 49'h1_2345_6789_ABCD with i_gap=0 -> o_vld high for 1 cycle, 2 cycles after acceptance; o_data = {7'd0, payload}; o_outstanding = 1.
- 4 pushes back-to-back with i_en=0 -> o_in_rdy drops after the 4th push and a 5th push is refused. Raise i_en -> 4 consecutive o_vld cycles with tags 0..3.
- 13 pushes, no i_ret_vld, MAX_OUTSTANDING=12 -> exactly 12 issues, outstanding = 12, state CREDIT_WAIT. One i_ret_vld -> 13th word issued the cycle after outstanding drops to 11.
- i_gap=3 with 3 queued words -> o_vld pulses spaced 4 cycles apart.
- i_ret_vld asserted with outstanding = 0 -> o_ovf_err = 1 and stays set. An issue and a return in the same cycle -> outstanding unchanged.
- 130 issues with returns -> tag wraps 127 -> 0. Assert i_rst with 3 words queued -> o_vld = 0, o_busy = 0, tag restarts at 0 on the next push.
